// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port data SRAM between the core LSU
// (master 0) and the debug-module system-bus access (master 1). It arbitrates
// round-robin, decodes the SRAM address window and routes the 1-cycle SRAM
// read response back to the master that was granted.
module dmem_port_arbiter #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MEM_ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = 32'h0101_0000
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic [1:0]                       m_req,
    output logic [1:0]                       m_gnt,
    input  logic [1:0][ADDR_WIDTH-1:0]       m_addr,
    input  logic [1:0]                       m_we,
    input  logic [1:0][DATA_WIDTH/8-1:0]     m_be,
    input  logic [1:0][DATA_WIDTH-1:0]       m_wdata,
    output logic [1:0]                       m_rvalid,
    output logic [1:0][DATA_WIDTH-1:0]       m_rdata,
    output logic [1:0]                       m_err,
    output logic                             sram_req,
    output logic                             sram_we,
    output logic [MEM_ADDR_WIDTH-1:0]        sram_addr,
    output logic [DATA_WIDTH/8-1:0]          sram_be,
    output logic [DATA_WIDTH-1:0]            sram_wdata,
    input  logic [DATA_WIDTH-1:0]            sram_rdata
);

    // Address bits above the SRAM word index select the window.
    localparam int TAG_LSB = MEM_ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:TAG_LSB] BASE_TAG = MEM_BASE[ADDR_WIDTH-1:TAG_LSB];

    logic rr_ptr;
    logic winner;
    logic grant_any;
    logic contended;
    logic win_hit;
    logic resp_valid;
    logic resp_owner;
    logic resp_err;
    logic resp_read;

    // Byte-lane selection is by byte enables only, so the two low address
    // bits are deliberately ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{m_addr[0][1:0], m_addr[1][1:0]};

    assign grant_any = |m_req;
    assign contended = &m_req;

    // Pick the winning master: a lone requester always wins, and under
    // contention the round-robin pointer decides.
    always_comb begin
        winner = 1'b0;
        if (contended) begin
            winner = rr_ptr;
        end else if (m_req[1]) begin
            winner = 1'b1;
        end
    end

    assign win_hit = (m_addr[winner][ADDR_WIDTH-1:TAG_LSB] == BASE_TAG);

    // Grant the winner in the same cycle and drive the SRAM only on a window
    // hit; all SRAM outputs rest at zero otherwise.
    always_comb begin
        m_gnt      = '0;
        sram_req   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = '0;
        sram_wdata = '0;
        if (grant_any) begin
            m_gnt[winner] = 1'b1;
            if (win_hit) begin
                sram_req   = 1'b1;
                sram_we    = m_we[winner];
                sram_addr  = m_addr[winner][TAG_LSB-1:2];
                sram_be    = m_be[winner];
                sram_wdata = m_wdata[winner];
            end
        end
    end

    // Track the round-robin pointer and remember who owns next cycle's
    // response; reset drops any response still in flight.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= 1'b0;
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
            resp_err   <= 1'b0;
            resp_read  <= 1'b0;
        end else begin
            if (contended) begin
                rr_ptr <= ~winner;
            end
            resp_valid <= grant_any;
            resp_owner <= winner;
            resp_err   <= grant_any & ~win_hit;
            resp_read  <= grant_any & win_hit & ~m_we[winner];
        end
    end

    // Route the response to its owner; read data is forwarded only for a
    // hit read and is zero for writes and window misses.
    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        m_err    = '0;
        if (resp_valid) begin
            m_rvalid[resp_owner] = 1'b1;
            m_err[resp_owner]    = resp_err;
            if (resp_read) begin
                m_rdata[resp_owner] = sram_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data SRAM in the SystemControl subsystem between two OBI-style masters.
- Master 0 is the core LSU. Master 1 is the debug-module system-bus access, used for JTAG program/data preload and for status polling.
- Provides round-robin arbitration, address-window decode with error response, and return routing for the SRAM's fixed 1-cycle read latency.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both master ports.
- DATA_WIDTH, 32, data width; must be 32.
- MEM_ADDR_WIDTH, 12, SRAM word-address width (4096 words, 16 KiB).
- MEM_BASE, 32'h0101_0000, byte base address of the window; must be aligned to the window size.

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_req  in  2  per-master request, bit0 = core, bit1 = debug.
- m_gnt  out  2  per-master grant; combinational from the same-cycle request.
- m_addr  in  2x32  per-master byte address.
- m_we  in  2  per-master write enable.
- m_be  in  2x4  per-master byte enables.
- m_wdata  in  2x32  per-master write data.
- m_rvalid  out  2  per-master response valid.
- m_rdata  out  2x32  per-master read data; 0 when m_rvalid is low for that master.
- m_err  out  2  per-master error, qualified by m_rvalid.
- sram_req  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  MEM_ADDR_WIDTH  SRAM word address, equal to m_addr[MEM_ADDR_WIDTH+1:2] of the granted master.
- sram_be  out  4  SRAM byte enables.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_req.

Behaviour:
- Reset (reset=0, asynchronous):
  - rr_ptr=0 (core preferred first); resp_valid=0; resp_owner=0; resp_err=0.
  - All outputs 0.
  - Reset released mid-transaction: the pending response is dropped and no rvalid is issued.
- Arbitration, each cycle:
  - Only one master requesting: it wins.
  - Both requesting: the master indicated by rr_ptr wins. rr_ptr then points to the loser, so back-to-back contention alternates 0,1,0,1.
  - rr_ptr updates only on a contended grant.
  - No request: no grant; sram_req=0; SRAM address/data outputs are held at 0.
- Grant: m_gnt[w]=1 in the same cycle as m_req[w] for the winner. The loser sees gnt=0 and must hold req and payload stable.
- Decode:
  - Hit condition: m_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == MEM_BASE[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2].
  - Hit: sram_req=1, and sram_we/be/wdata/addr are driven from the winner.
  - Miss: still granted, sram_req=0, resp_err set.
- Response:
  - Registered state: resp_valid<=grant_any, resp_owner<=winner, resp_err<=miss.
  - Next cycle: m_rvalid[resp_owner]=resp_valid.
  - m_rdata[resp_owner] = sram_rdata for a hit read; 0 for a write or a miss.
  - m_err[resp_owner] = resp_err.
  - Latency is exactly 1 cycle from grant to rvalid, for both reads and writes.
- Pipelining:
  - A new grant may occur in the same cycle as the previous response, giving full throughput of 1 access per cycle.
  - No response buffering: masters must accept rvalid unconditionally.
- Simultaneous write and read to the same word in consecutive cycles: the read returns the newly written data. This is a property of the SRAM model and is checked in test, not added logic.
- Misaligned low address bits [1:0] are ignored; byte selection is by be only.
- sram_be=0 on a hit write still issues sram_req (no-op write) and returns rvalid with err=0.

Test Plan:
1. Reset, then core read at 0x0101_0010 with SRAM word 4 = 0xDEAD_BEEF -> same cycle gnt[0]=1, sram_addr=4; next cycle rvalid[0]=1, rdata[0]=0xDEAD_BEEF, err[0]=0.
2. Both masters request every cycle for 4 cycles (core reads, debug writes 0x1234_5678 be=4'hF to 0x0101_0380) -> grants 0,1,0,1; sram_we high only on debug cycles; each rvalid lands on the correct owner exactly 1 cycle later.
3. Debug read at 0x0102_0380 (outside window) -> gnt[1]=1, sram_req=0; next cycle rvalid[1]=1, err[1]=1, rdata[1]=0.
4. Write 0xA5 with be=4'b0001 to word 0x20, then read it back -> sram_be=1 on the write; readback low byte = 0xA5, upper bytes unchanged.
5. Core reads back-to-back for 3 cycles -> 3 grants, 3 rvalids, no bubbles; rr_ptr stays 0.
6. Assert reset while a debug read is granted -> no m_rvalid after reset release; first post-reset contended cycle grants core.
